// File: rtl/operand_selector.sv
// Operand selector: picks operand slot IDs for the current op (switch entry or auto scan),
// reads each operand's dimensions from matrix storage and checks them against the op.
module operand_selector #(
  parameter int NUM_SLOTS = 16,
  parameter int DIM_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_select,
  input  logic                 manual_mode,
  input  logic [2:0]           op_sel,
  input  logic                 key_ok,
  input  logic [3:0]           sw_id,
  input  logic [NUM_SLOTS-1:0] slot_valid,
  output logic [3:0]           dim_rd_id,
  input  logic [DIM_W-1:0]     dim_rd_rows,
  input  logic [DIM_W-1:0]     dim_rd_cols,
  output logic                 select_done,
  output logic                 select_error,
  output logic [3:0]           selected_a,
  output logic [3:0]           selected_b,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam logic [2:0] OP_TRANSPOSE = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_SCALAR    = 3'b010;
  localparam logic [2:0] OP_MATMUL    = 3'b011;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_BAD_ID = 2'd1;
  localparam logic [1:0] ERR_DIM    = 2'd2;
  localparam logic [1:0] ERR_NO_OP  = 2'd3;

  localparam logic [3:0] LAST_ID = 4'(NUM_SLOTS - 1);

  typedef enum logic [3:0] {
    IDLE, PICK_A, PICK_B, SCAN_A, SCAN_B, RD_A, CAP_A, RD_B, CAP_B, CHECK, DONE, ERR
  } state_t;

  state_t           state, state_n;
  logic             mode, mode_n;
  logic [2:0]       op, op_n;
  logic [3:0]       a_id, a_id_n, b_id, b_id_n;
  logic [3:0]       scan_idx, scan_idx_n;
  logic [DIM_W-1:0] a_rows, a_rows_n, a_cols, a_cols_n;
  logic [DIM_W-1:0] b_rows, b_rows_n, b_cols, b_cols_n;
  logic             wrapped, wrapped_n;
  logic [1:0]       err_code_n;
  logic [3:0]       selected_a_n, selected_b_n;

  logic sw_valid, scan_valid, unary, dims_match;

  function automatic logic [3:0] next_id(input logic [3:0] id);
    return (id == LAST_ID) ? 4'd0 : id + 4'd1;
  endfunction

  function automatic logic op_known(input logic [2:0] code);
    return (code == OP_TRANSPOSE) || (code == OP_ADD) ||
           (code == OP_SCALAR)    || (code == OP_MATMUL);
  endfunction

  assign sw_valid   = (32'(sw_id) < NUM_SLOTS) && slot_valid[sw_id];
  assign scan_valid = slot_valid[scan_idx];
  assign unary      = (op == OP_TRANSPOSE) || (op == OP_SCALAR);

  always_comb begin
    dims_match = 1'b1;
    if (op == OP_ADD)
      dims_match = (a_rows == b_rows) && (a_cols == b_cols);
    else if (op == OP_MATMUL)
      dims_match = (a_cols == b_rows);
  end

  // NOTE: every variable written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_n      = state;
    mode_n       = mode;
    op_n         = op;
    a_id_n       = a_id;
    b_id_n       = b_id;
    scan_idx_n   = scan_idx;
    a_rows_n     = a_rows;
    a_cols_n     = a_cols;
    b_rows_n     = b_rows;
    b_cols_n     = b_cols;
    wrapped_n    = wrapped;
    err_code_n   = err_code;
    selected_a_n = selected_a;
    selected_b_n = selected_b;

    if (start_select) begin
      // Restart wins over everything, whatever state we were in.
      err_code_n = ERR_NONE;
      mode_n     = manual_mode;
      op_n       = op_sel;
      wrapped_n  = 1'b0;
      scan_idx_n = 4'd0;
      if (!op_known(op_sel)) begin
        state_n    = ERR;
        err_code_n = ERR_NO_OP;
      end else begin
        state_n = manual_mode ? PICK_A : SCAN_A;
      end
    end else begin
      unique case (state)
        IDLE, DONE: ;
        PICK_A: if (key_ok) begin
          if (!sw_valid) begin
            state_n    = ERR;
            err_code_n = ERR_BAD_ID;
          end else begin
            a_id_n  = sw_id;
            b_id_n  = sw_id;
            state_n = unary ? RD_A : PICK_B;
          end
        end
        PICK_B: if (key_ok) begin
          if (!sw_valid) begin
            state_n    = ERR;
            err_code_n = ERR_BAD_ID;
          end else begin
            b_id_n  = sw_id;
            state_n = RD_A;
          end
        end
        SCAN_A: begin
          if (scan_valid) begin
            a_id_n = scan_idx;
            b_id_n = scan_idx;
            if (unary) begin
              state_n = RD_A;
            end else begin
              scan_idx_n = next_id(scan_idx);
              state_n    = SCAN_B;
            end
          end else if (scan_idx == LAST_ID) begin
            state_n    = ERR;
            err_code_n = ERR_NO_OP;
          end else begin
            scan_idx_n = next_id(scan_idx);
          end
        end
        SCAN_B: begin
          // Coming back round to A means A is the last candidate left.
          if (scan_idx == a_id) begin
            b_id_n    = a_id;
            wrapped_n = 1'b1;
            state_n   = RD_A;
          end else if (scan_valid) begin
            b_id_n  = scan_idx;
            state_n = RD_A;
          end else begin
            scan_idx_n = next_id(scan_idx);
          end
        end
        RD_A: state_n = CAP_A;
        CAP_A: begin
          a_rows_n = dim_rd_rows;
          a_cols_n = dim_rd_cols;
          if (dim_rd_rows == '0 || dim_rd_cols == '0) begin
            state_n    = ERR;
            err_code_n = ERR_BAD_ID;
          end else begin
            state_n = unary ? CHECK : RD_B;
          end
        end
        RD_B: state_n = CAP_B;
        CAP_B: begin
          b_rows_n = dim_rd_rows;
          b_cols_n = dim_rd_cols;
          if (dim_rd_rows == '0 || dim_rd_cols == '0) begin
            state_n    = ERR;
            err_code_n = ERR_BAD_ID;
          end else begin
            state_n = CHECK;
          end
        end
        CHECK: begin
          if (dims_match) begin
            selected_a_n = a_id;
            selected_b_n = b_id;
            state_n      = DONE;
          end else if (mode || wrapped) begin
            state_n    = ERR;
            err_code_n = ERR_DIM;
          end else begin
            scan_idx_n = next_id(b_id);
            state_n    = SCAN_B;
          end
        end
        ERR:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= 1'b0;
      op         <= 3'd0;
      a_id       <= 4'd0;
      b_id       <= 4'd0;
      scan_idx   <= 4'd0;
      a_rows     <= '0;
      a_cols     <= '0;
      b_rows     <= '0;
      b_cols     <= '0;
      wrapped    <= 1'b0;
      err_code   <= ERR_NONE;
      selected_a <= 4'd0;
      selected_b <= 4'd0;
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      op         <= op_n;
      a_id       <= a_id_n;
      b_id       <= b_id_n;
      scan_idx   <= scan_idx_n;
      a_rows     <= a_rows_n;
      a_cols     <= a_cols_n;
      b_rows     <= b_rows_n;
      b_cols     <= b_cols_n;
      wrapped    <= wrapped_n;
      err_code   <= err_code_n;
      selected_a <= selected_a_n;
      selected_b <= selected_b_n;
    end
  end

  // Storage read data lands in CAP_x, one cycle after the address is shown in RD_x.
  assign dim_rd_id    = (state == RD_B || state == CAP_B) ? b_id : a_id;
  assign select_done  = (state == DONE);
  assign select_error = (state == ERR);
  assign busy         = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_operand_selector.sv
// Directed bench for operand_selector with a registered-read dimension storage model.
module tb_operand_selector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_select, manual_mode, key_ok;
  logic [2:0]  op_sel;
  logic [3:0]  sw_id;
  logic [15:0] slot_valid;
  logic [3:0]  dim_rd_id;
  logic [2:0]  dim_rd_rows, dim_rd_cols;
  logic        select_done, select_error, busy;
  logic [3:0]  selected_a, selected_b;
  logic [1:0]  err_code;

  logic [2:0] mem_rows [16];
  logic [2:0] mem_cols [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_selector #(.NUM_SLOTS(16), .DIM_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_select(start_select), .manual_mode(manual_mode),
    .op_sel(op_sel), .key_ok(key_ok), .sw_id(sw_id), .slot_valid(slot_valid),
    .dim_rd_id(dim_rd_id), .dim_rd_rows(dim_rd_rows), .dim_rd_cols(dim_rd_cols),
    .select_done(select_done), .select_error(select_error), .selected_a(selected_a),
    .selected_b(selected_b), .err_code(err_code), .busy(busy)
  );

  always @(posedge clk) begin
    dim_rd_rows <= mem_rows[dim_rd_id];
    dim_rd_cols <= mem_cols[dim_rd_id];
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_rows[i] = 3'd0;
      mem_cols[i] = 3'd0;
    end
    slot_valid = 16'h0;
  endtask

  task automatic set_slot(input int id, input logic [2:0] r, input logic [2:0] c);
    mem_rows[id]   = r;
    mem_cols[id]   = c;
    slot_valid[id] = 1'b1;
  endtask

  // All stimulus tasks begin and end on a falling edge.
  task automatic start(input logic manual, input logic [2:0] op);
    manual_mode  = manual;
    op_sel       = op;
    start_select = 1'b1;
    @(negedge clk);
    start_select = 1'b0;
  endtask

  task automatic key(input logic [3:0] id);
    sw_id  = id;
    key_ok = 1'b1;
    @(negedge clk);
    key_ok = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 200; i++) begin
      if (select_done || select_error) break;
      @(negedge clk);
    end
    total++;
    if (!(select_done || select_error)) begin
      bad++;
      $display("FAIL wait_result: no done/error within 200 cycles");
    end
  endtask

  task automatic expect_done(input string name, input logic [3:0] a, input logic [3:0] b);
    total++;
    if (select_done !== 1'b1) begin
      bad++; $display("FAIL %s done: got %b want 1", name, select_done);
    end
    total++;
    if (selected_a !== a || selected_b !== b) begin
      bad++; $display("FAIL %s ids: got a=%0d b=%0d want a=%0d b=%0d", name, selected_a, selected_b, a, b);
    end
    total++;
    if (err_code !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s err/busy: got err=%0d busy=%b want 0/0", name, err_code, busy);
    end
  endtask

  task automatic expect_err(input string name, input logic [1:0] code);
    total++;
    if (select_error !== 1'b1 || select_done !== 1'b0) begin
      bad++; $display("FAIL %s err pulse: got err=%b done=%b want 1/0", name, select_error, select_done);
    end
    total++;
    if (err_code !== code) begin
      bad++; $display("FAIL %s code: got %0d want %0d", name, err_code, code);
    end
    @(negedge clk);
    total++;
    if (select_error !== 1'b0 || err_code !== code || busy !== 1'b0) begin
      bad++; $display("FAIL %s after pulse: got err=%b code=%0d busy=%b want 0/%0d/0",
                      name, select_error, err_code, busy, code);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({select_done, select_error, selected_a, selected_b, err_code, busy, dim_rd_id} !== 19'd0) begin
      bad++; $display("FAIL reset outputs: got %h want 0",
                      {select_done, select_error, selected_a, selected_b, err_code, busy, dim_rd_id});
    end
  endtask

  task automatic test_manual_add();
    clear_mem(); set_slot(2, 3'd3, 3'd3); set_slot(5, 3'd3, 3'd3);
    start(1'b1, 3'b001); key(4'd2); key(4'd5);
    wait_result(); expect_done("manual_add", 4'd2, 4'd5);
  endtask

  task automatic test_manual_latency();
    clear_mem(); set_slot(6, 3'd2, 3'd4);
    start(1'b1, 3'b000); key(4'd6);
    repeat (2) @(negedge clk);
    total++;
    if (select_done !== 1'b0) begin
      bad++; $display("FAIL latency t+3: got done=%b want 0", select_done);
    end
    @(negedge clk);
    expect_done("latency t+4", 4'd6, 4'd6);
  endtask

  task automatic test_manual_bad_id();
    clear_mem(); set_slot(2, 3'd3, 3'd3);
    start(1'b1, 3'b001); key(4'd7);
    wait_result(); expect_err("manual_bad_id", 2'd1);
  endtask

  task automatic test_manual_mismatch();
    clear_mem(); set_slot(2, 3'd3, 3'd3); set_slot(5, 3'd2, 3'd3);
    start(1'b1, 3'b001); key(4'd2); key(4'd5);
    wait_result(); expect_err("manual_mismatch", 2'd2);
  endtask

  task automatic test_auto_matmul();
    clear_mem(); set_slot(1, 3'd2, 3'd3); set_slot(4, 3'd2, 3'd2); set_slot(9, 3'd3, 3'd4);
    start(1'b0, 3'b011);
    wait_result(); expect_done("auto_matmul", 4'd1, 4'd9);
  endtask

  task automatic test_auto_boundaries();
    clear_mem();
    start(1'b0, 3'b001);
    wait_result(); expect_err("auto_empty", 2'd3);
    clear_mem(); set_slot(0, 3'd4, 3'd2);
    start(1'b0, 3'b000);
    wait_result(); expect_done("auto_single_unary", 4'd0, 4'd0);
    clear_mem(); set_slot(3, 3'd2, 3'd2);
    start(1'b0, 3'b011);
    wait_result(); expect_done("auto_wrap_pass", 4'd3, 4'd3);
    clear_mem(); set_slot(3, 3'd2, 3'd3);
    start(1'b0, 3'b011);
    wait_result(); expect_err("auto_wrap_fail", 2'd2);
  endtask

  task automatic test_bad_op_and_zero_dim();
    clear_mem(); set_slot(4, 3'd0, 3'd2);
    start(1'b1, 3'b101);
    expect_err("bad_op", 2'd3);
    start(1'b1, 3'b010); key(4'd4);
    wait_result(); expect_err("zero_dim", 2'd1);
  endtask

  task automatic test_restart();
    clear_mem(); set_slot(2, 3'd3, 3'd3); set_slot(5, 3'd3, 3'd3);
    start(1'b1, 3'b000); key(4'd2);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || dim_rd_id !== 4'd2) begin
      bad++; $display("FAIL restart pre: got busy=%b rd=%0d want 1/2", busy, dim_rd_id);
    end
    start(1'b0, 3'b001);
    wait_result(); expect_done("restart", 4'd2, 4'd5);
  endtask

  task automatic test_reset_mid_scan();
    clear_mem(); set_slot(0, 3'd2, 3'd2); set_slot(15, 3'd2, 3'd2);
    start(1'b0, 3'b001);
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_scan busy: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1 test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || select_done !== 1'b0) begin
      bad++; $display("FAIL post_reset idle: got busy=%b done=%b want 0/0", busy, select_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_select = 1'b0; manual_mode = 1'b0; op_sel = 3'd0;
    key_ok = 1'b0; sw_id = 4'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_manual_add();
    test_manual_latency();
    test_manual_bad_id();
    test_manual_mismatch();
    test_auto_matmul();
    test_auto_boundaries();
    test_bad_op_and_zero_dim();
    test_restart();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
